// File: rtl/adder_result_acc.sv
// Frame accumulator for the adder result stream.
// Sums every `count` consecutive valid results into one total and queues the
// totals in a 2-entry FIFO drained by a ready/valid consumer. The input can
// never be stalled, so a frame that completes while the FIFO is full (and not
// being popped) is dropped, and the sticky overflow flag records the loss.
module adder_result_acc #(
   parameter int bits  = 16,
   parameter int count = 4,
   localparam int cw   = $clog2(count),
   localparam int ow   = bits + cw
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            valid,
   input  logic [bits-1:0] i,
   output logic [ow-1:0]   o,
   output logic            valid_out,
   input  logic            ready,
   output logic [1:0]      level,
   output logic            overflow
);

   // Samples remaining in the frame, counted down; the terminal count (0)
   // marks the last sample, the top value marks the first.
   localparam logic [cw-1:0] cnt_top = cw'(count - 1);

   logic [cw-1:0] left;
   logic [ow-1:0] acc;
   logic [ow-1:0] sum;
   logic [ow-1:0] head;
   logic [ow-1:0] second;
   logic          first;
   logic          last;
   logic          push;
   logic          pop;

   assign first     = (left == cnt_top);
   assign last      = (left == '0);
   assign push      = valid && last;
   assign valid_out = (level != 2'd0);
   assign pop       = valid_out && ready;
   assign o         = head;

   // Running sum; the first sample of a frame ignores whatever acc holds.
   always_comb begin
      sum = (first ? '0 : acc) + {{cw{1'b0}}, i};
   end

   // Sample counter and accumulator; both hold across gaps in valid.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         left <= cnt_top;
         acc  <= '0;
      end else if (valid) begin
         acc <= sum;
         if (last)
            left <= cnt_top;
         else
            left <= left - cw'(1);
      end
   end

   // Two-entry FIFO with push/pop resolution and sticky drop flag.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         head     <= '0;
         second   <= '0;
         level    <= 2'd0;
         overflow <= 1'b0;
      end else begin
         if (push && pop) begin
            // Occupancy unchanged; the new total lands behind what remains.
            if (level == 2'd2) begin
               head   <= second;
               second <= sum;
            end else begin
               head <= sum;
            end
         end else if (push) begin
            if (level == 2'd0) begin
               head  <= sum;
               level <= 2'd1;
            end else if (level == 2'd1) begin
               second <= sum;
               level  <= 2'd2;
            end else begin
               overflow <= 1'b1;
            end
         end else if (pop) begin
            head  <= second;
            level <= level - 2'd1;
         end
      end
   end

endmodule

// File: tb/tb_adder_result_acc.sv
// Bench for adder_result_acc: directed scenarios plus a randomized run, all
// checked every cycle against a queue-based model of frames and the FIFO.
module tb_adder_result_acc;

   localparam int BITS  = 16;
   localparam int COUNT = 4;
   localparam int OW    = BITS + $clog2(COUNT);

   logic            clk = 1'b0;
   logic            resetn;
   logic            valid;
   logic [BITS-1:0] i;
   logic [OW-1:0]   o;
   logic            valid_out;
   logic            ready;
   logic [1:0]      level;
   logic            overflow;

   int total = 0;
   int bad   = 0;

   // reference model state
   longint unsigned fifo_m[$];
   longint unsigned part_m[$];
   bit              ovf_m;

   adder_result_acc #(.bits(BITS), .count(COUNT)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .valid     (valid),
      .i         (i),
      .o         (o),
      .valid_out (valid_out),
      .ready     (ready),
      .level     (level),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Frame semantics: a total is the plain sum of COUNT samples; the buffer
   // is a 2-deep FIFO where a pop frees room for a simultaneous push.
   task automatic model_edge(input bit v, input longint unsigned d, input bit r);
      longint unsigned tot;
      if (r && fifo_m.size() != 0) void'(fifo_m.pop_front());
      if (v) begin
         part_m.push_back(d);
         if (part_m.size() == COUNT) begin
            tot = 0;
            foreach (part_m[k]) tot += part_m[k];
            part_m.delete();
            if (fifo_m.size() < 2) fifo_m.push_back(tot);
            else ovf_m = 1'b1;
         end
      end
   endtask

   task automatic check_outputs();
      chk("level", 64'(level), 64'(fifo_m.size()));
      chk("valid_out", 64'(valid_out), 64'(fifo_m.size() != 0));
      chk("overflow", 64'(overflow), 64'(ovf_m));
      if (fifo_m.size() != 0) chk("o", 64'(o), fifo_m[0]);
   endtask

   task automatic step(input bit v, input logic [BITS-1:0] d, input bit r);
      valid = v;
      i     = d;
      ready = r;
      @(posedge clk);
      #1;
      model_edge(v, longint'(d), r);
      check_outputs();
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      valid  = 1'b0;
      ready  = 1'b0;
      i      = '0;
      #1;
      repeat (2) begin
         chk("rst_o", 64'(o), 64'd0);
         chk("rst_valid_out", 64'(valid_out), 64'd0);
         chk("rst_level", 64'(level), 64'd0);
         chk("rst_overflow", 64'(overflow), 64'd0);
         @(posedge clk);
         #1;
      end
      fifo_m.delete();
      part_m.delete();
      ovf_m = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
   endtask

   task automatic frame(input logic [BITS-1:0] d, input bit r);
      repeat (COUNT) step(1'b1, d, r);
   endtask

   initial begin
      resetn = 1'b0;
      valid  = 1'b0;
      ready  = 1'b0;
      i      = '0;
      ovf_m  = 1'b0;

      // basic 1,2,3,4 -> 10, one cycle later, then drained
      do_reset();
      step(1, 16'd1, 1); step(1, 16'd2, 1); step(1, 16'd3, 1); step(1, 16'd4, 1);
      chk("sum10", 64'(o), 64'd10);
      step(0, 16'd0, 1);
      chk("sum10_gone", 64'(valid_out), 64'd0);

      // full-scale frame, then accumulator restart
      frame(16'hFFFF, 1);
      chk("full_scale", 64'(o), 64'h3FFFC);
      step(1, 16'd0, 1); step(1, 16'd0, 1); step(1, 16'd0, 1); step(1, 16'd5, 1);
      chk("restart", 64'(o), 64'd5);
      step(0, 16'd0, 1);

      // overflow with stalled consumer, then drain
      frame(16'd1, 0); frame(16'd2, 0); frame(16'd3, 0);
      chk("ovf_level", 64'(level), 64'd2);
      chk("ovf_flag", 64'(overflow), 64'd1);
      repeat (3) step(0, 16'd0, 1);
      chk("ovf_sticky", 64'(overflow), 64'd1);

      // push and pop at level 2 in the same cycle
      do_reset();
      frame(16'd1, 0); frame(16'd2, 0);
      step(1, 16'd5, 0); step(1, 16'd5, 0); step(1, 16'd5, 0); step(1, 16'd5, 1);
      chk("pp_level", 64'(level), 64'd2);
      chk("pp_head", 64'(o), 64'd8);
      chk("pp_ovf", 64'(overflow), 64'd0);
      step(0, 16'd0, 1);
      chk("pp_second", 64'(o), 64'd20);
      step(0, 16'd0, 1);

      // reset mid-frame discards partial sum
      step(1, 16'd7, 1); step(1, 16'd7, 1);
      do_reset();
      frame(16'd1, 1);
      chk("post_reset", 64'(o), 64'd4);
      step(0, 16'd0, 1);

      // gaps between samples
      for (int k = 1; k <= 4; k++) begin
         repeat ($urandom_range(0, 5)) step(0, BITS'($urandom), 1);
         step(1, BITS'(k), 1);
      end
      chk("gaps", 64'(o), 64'd10);
      step(0, 16'd0, 1);

      // randomized traffic with random backpressure
      do_reset();
      for (int n = 0; n < 3000; n++)
         step($urandom_range(0, 9) < 7, BITS'($urandom), $urandom_range(0, 1) == 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
